// File: rtl/vga_stream_source.sv
// vga_stream_source
//   Avalon-ST video source feeding the VGA sink. Camera pixels (RGB444) are
//   captured from a frame-start marker onwards into a small FIFO and replayed
//   as fixed-length packets of WIDTH*HEIGHT beats. A camera frame that
//   overflows the FIFO or restarts early is closed with black padding, so
//   the sink always receives a complete packet.
//
// Ports
//   clk_clk            : single clock
//   reset_reset_n      : asynchronous active-low reset (deassertion synchronised here)
//   pix_valid          : camera pixel strobe
//   pix_data           : camera pixel
//   pix_sof            : first pixel of a camera frame (qualified by pix_valid)
//   out_data           : stream pixel (registered)
//   out_valid          : beat valid (registered)
//   out_startofpacket  : first beat of a packet (registered)
//   out_endofpacket    : last beat of a packet (registered)
//   out_ready          : sink ready, ready latency 0
//   overflow_sticky    : a frame was dropped or padded since reset
//   frame_count        : packets emitted, wraps 255 -> 0
module vga_stream_source #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  input  logic              out_ready,
  output logic              overflow_sticky,
  output logic [7:0]        frame_count
);

  localparam int unsigned N      = WIDTH * HEIGHT;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WCNT_W = $clog2(N + 1);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = AW + 1;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_DONE,
    WR_DROP
  } wr_state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop at once, release is
  // aligned to the clock two edges later.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Storage and handshake terms
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [OCC_W-1:0]  occ;
  logic              fifo_empty;
  logic              room;

  wr_state_t         wr_state;
  logic [WCNT_W-1:0] wr_cnt;
  logic              push;
  logic              abort;

  logic [CNT_W-1:0]  rd_cnt;
  logic              pad_req;
  logic              xfer;
  logic              eop_xfer;
  logic              load;
  logic              beat_avail;
  logic              pop;
  logic              last_beat;

  assign fifo_empty = (fifo_cnt == '0);
  assign xfer       = out_valid && out_ready;
  assign eop_xfer   = xfer && out_endofpacket;
  // The output register refills whenever it is empty or being drained.
  assign load       = !out_valid || out_ready;
  assign beat_avail = !fifo_empty || pad_req;
  assign pop        = load && !fifo_empty;
  assign last_beat  = (rd_cnt == CNT_W'(N - 1));

  // Capacity counts the output register as one of the FIFO_DEPTH slots, and a
  // beat leaving this cycle frees its slot for a pixel arriving this cycle.
  assign occ  = fifo_cnt + OCC_W'(out_valid);
  assign room = (occ - OCC_W'(xfer)) < OCC_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Write-side decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    push  = 1'b0;
    abort = 1'b0;
    case (wr_state)
      // The previous packet has fully left before WR_IDLE is re-entered, so
      // the FIFO always has room for the first pixel of a frame.
      WR_IDLE: push = pix_valid && pix_sof;
      WR_ACTIVE: begin
        if (pix_valid) begin
          if (pix_sof || !room) begin
            abort = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: begin
        push  = 1'b0;
        abort = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state        <= WR_IDLE;
      wr_cnt          <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (push) begin
            wr_cnt   <= WCNT_W'(1);
            wr_state <= (N == 1) ? WR_DONE : WR_ACTIVE;
          end
        end
        WR_ACTIVE: begin
          if (abort) begin
            overflow_sticky <= 1'b1;
            wr_state        <= WR_DROP;
          end else if (push) begin
            wr_cnt <= wr_cnt + WCNT_W'(1);
            if (wr_cnt == WCNT_W'(N - 1)) begin
              wr_state <= WR_DONE;
            end
          end
        end
        default: begin
          // WR_DONE / WR_DROP: camera input ignored until the packet has left.
          if (eop_xfer) begin
            wr_state <= WR_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_cnt <= fifo_cnt + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  //   rd_cnt is the packet index of the next beat entering the output
  //   register; since that register only refills on a transfer or when empty,
  //   sop/eop derived from it always describe the beat being presented.
  //   pad_req is dropped as soon as the end-of-packet beat is committed, so at
  //   rd_cnt==0 a set pad_req can only belong to a frame that aborted before
  //   any of its beats was sent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      rd_cnt            <= '0;
      pad_req           <= 1'b0;
      frame_count       <= '0;
    end else begin
      if (eop_xfer) begin
        frame_count <= frame_count + 8'd1;
      end

      if (load) begin
        if (beat_avail) begin
          out_valid         <= 1'b1;
          out_data          <= fifo_empty ? '0 : mem[rd_ptr];
          out_startofpacket <= (rd_cnt == '0);
          out_endofpacket   <= last_beat;
          rd_cnt            <= last_beat ? '0 : rd_cnt + CNT_W'(1);
        end else begin
          out_valid         <= 1'b0;
          out_startofpacket <= 1'b0;
          out_endofpacket   <= 1'b0;
        end
      end

      if (abort) begin
        pad_req <= 1'b1;
      end else if (load && beat_avail && last_beat) begin
        pad_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_source.sv
// tb_vga_stream_source
//   Directed bench for vga_stream_source built with a 4x2 frame and a 4-entry
//   FIFO. Inputs change 1 time unit after the rising edge; outputs are read on
//   the falling edge. Every accepted beat is logged as {sop, eop, data}.
module tb_vga_stream_source;

  localparam int unsigned DW = 12;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_sof;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          overflow;
  logic [7:0]    frame_count;

  int compared   = 0;
  int mismatched = 0;

  logic [DW+1:0] beats[$];

  always #5 clk = ~clk;

  vga_stream_source #(
    .WIDTH      (4),
    .HEIGHT     (2),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_sof           (pix_sof),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_ready         (out_ready),
    .overflow_sticky   (overflow),
    .frame_count       (frame_count)
  );

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beats.push_back({out_sop, out_eop, out_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  task automatic drive_pix(input logic [DW-1:0] d, input logic sof);
    step();
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
  endtask

  task automatic apply_reset();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    beats.delete();
  endtask

  task automatic test_reset();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) step();
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
    compared++; if (out_sop !== 1'b0) begin mismatched++; $display("FAIL reset_sop got %b want 0", out_sop); end
    compared++; if (out_eop !== 1'b0) begin mismatched++; $display("FAIL reset_eop got %b want 0", out_eop); end
    compared++; if (out_data !== 12'h000) begin mismatched++; $display("FAIL reset_data got %h want 000", out_data); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got %b want 0", overflow); end
    compared++; if (frame_count !== 8'd0) begin mismatched++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_pix(DW'(i + 1), i == 0);
      @(negedge clk);
      if (i == 1) begin
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_latency_early got %b want 0", out_valid); end
      end
      if (i == 2) begin
        compared++;
        if ({out_valid, out_sop, out_data} !== {1'b1, 1'b1, 12'h001}) begin
          mismatched++; $display("FAIL basic_latency got v=%b sop=%b d=%h want v=1 sop=1 d=001", out_valid, out_sop, out_data);
        end
      end
    end
    idle(10);
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL basic_beat_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, DW'(i + 1)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL basic_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL basic_overflow got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    logic          held;
    logic [DW+1:0] held_val;
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    apply_reset();
    held     = 1'b0;
    held_val = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      pix_valid = (c < 16) && ((c % 2) == 0);
      pix_sof   = (c == 0);
      pix_data  = DW'(c / 2 + 1);
      out_ready = (c % 2) == 1;
      @(negedge clk);
      if (held) begin
        compared++;
        if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, held_val}) begin
          mismatched++; $display("FAIL stall_hold cycle %0d got v=%b %h want v=1 %h", c, out_valid, {out_sop, out_eop, out_data}, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = {out_sop, out_eop, out_data};
    end
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL bp_beat_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, DW'(i + 1)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL bp_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("FAIL bp_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_overflow();
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_pix(DW'(i + 1), i == 0);
    idle(2);
    @(negedge clk);
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    compared++;
    if ({out_valid, out_sop, out_data} !== {1'b1, 1'b1, 12'h001}) begin
      mismatched++; $display("FAIL ovf_stalled_head got v=%b sop=%b d=%h want v=1 sop=1 d=001", out_valid, out_sop, out_data);
    end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_pix(12'h0AA, 1'b0);
    idle(14);
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL ovf_beat_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, (i < 4) ? DW'(i + 1) : DW'(0)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL ovf_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("FAIL ovf_frame_count got %0d want 1", frame_count); end
    beats.delete();
    for (int i = 0; i < 8; i++) drive_pix(DW'(8'h11 + i), i == 0);
    idle(12);
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL ovf_next_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, DW'(8'h11 + i)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL ovf_next_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("FAIL ovf_next_frame_count got %0d want 2", frame_count); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky_kept got %b want 1", overflow); end
  endtask

  task automatic test_early_sof();
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    logic [DW-1:0] wd;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_pix(DW'(i + 1), i == 0);
    for (int i = 0; i < 8; i++) drive_pix(DW'(8'h21 + i), i == 0);
    idle(4);
    for (int i = 0; i < 8; i++) drive_pix(DW'(8'h31 + i), i == 0);
    idle(12);
    compared++; if (beats.size() != 16) begin mismatched++; $display("FAIL early_beat_count got %0d want 16", beats.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < 3)      wd = DW'(i + 1);
      else if (i < 8) wd = DW'(0);
      else            wd = DW'(8'h31 + i - 8);
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {(i == 0) || (i == 8), (i == 7) || (i == 15), wd};
      compared++; if (got !== want) begin mismatched++; $display("FAIL early_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("FAIL early_frame_count got %0d want 2", frame_count); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL early_overflow got %b want 1", overflow); end
  endtask

  task automatic test_excess();
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive_pix(DW'(8'h41 + i), i == 0);
    idle(8);
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL excess_beat_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, DW'(8'h41 + i)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL excess_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("FAIL excess_frame_count got %0d want 1", frame_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL excess_overflow got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_pix(DW'(8'h51 + i), i == 0);
    @(negedge clk);
    compared++;
    if ({out_valid, out_sop} !== 2'b11) begin
      mismatched++; $display("FAIL midrst_pre got v=%b sop=%b want v=1 sop=1", out_valid, out_sop);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, out_sop, out_eop} !== 3'b000) begin
      mismatched++; $display("FAIL midrst_async got v=%b sop=%b eop=%b want 000", out_valid, out_sop, out_eop);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    beats.delete();
    for (int i = 0; i < 8; i++) drive_pix(DW'(8'h61 + i), i == 0);
    idle(10);
    compared++; if (beats.size() != 8) begin mismatched++; $display("FAIL midrst_beat_count got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      got  = (i < beats.size()) ? beats[i] : '1;
      want = {i == 0, i == 7, DW'(8'h61 + i)};
      compared++; if (got !== want) begin mismatched++; $display("FAIL midrst_beat%0d got %h want %h", i, got, want); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("FAIL midrst_frame_count got %0d want 1", frame_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_early_sof();
    test_excess();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
